// File: rtl/imem_loadable.sv
// imem_loadable: byte-addressed instruction memory with a registered fetch
// port and a byte-serial program loader. Self-clears after reset.
// Build option: define IMEM_LITTLE_ENDIAN_EN for RISC-V native byte order
// on fetch_data; leave undefined for big-endian image order.
module imem_loadable #(
  parameter int unsigned MEM_SIZE    = 128,
  parameter int unsigned WORD_SIZE   = 8,
  parameter int unsigned FETCH_BYTES = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             fetch_req,
  input  logic [$clog2(MEM_SIZE)-1:0]      fetch_addr,
  output logic                             fetch_ready,
  output logic                             fetch_valid,
  output logic [WORD_SIZE*FETCH_BYTES-1:0] fetch_data,
  output logic                             fetch_misaligned,
  input  logic                             load_start,
  input  logic                             load_valid,
  input  logic [WORD_SIZE-1:0]             load_data,
  input  logic                             load_last,
  output logic                             load_ready,
  output logic                             load_done,
  output logic                             busy
);

  localparam int unsigned AW = $clog2(MEM_SIZE);
  localparam int unsigned DW = WORD_SIZE * FETCH_BYTES;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  state_t                 state_q;
  state_t                 state_nxt;
  logic [AW-1:0]          ptr_q;
  logic [AW-1:0]          ptr_nxt;
  logic                   mem_we_c;
  logic [WORD_SIZE-1:0]   mem_wdata_c;
  logic                   load_done_nxt;
  logic                   fetch_acc_c;
  logic                   fetch_mis_c;
  logic [DW-1:0]          rd_word_c;

  logic [WORD_SIZE-1:0]   mem [MEM_SIZE];

  // State and shared clear/load pointer register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_nxt;
      ptr_q   <= ptr_nxt;
    end
  end

  // Next-state, pointer and write-port decode
  always_comb begin
    state_nxt     = state_q;
    ptr_nxt       = ptr_q;
    mem_we_c      = 1'b0;
    mem_wdata_c   = '0;
    load_done_nxt = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        mem_we_c = 1'b1;
        ptr_nxt  = ptr_q + AW'(1);
        if (ptr_q == AW'(MEM_SIZE - 1)) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (load_start) begin
          state_nxt = ST_LOAD;
          ptr_nxt   = '0;
        end
      end
      ST_LOAD: begin
        if (load_valid && load_ready) begin
          mem_we_c    = 1'b1;
          mem_wdata_c = load_data;
          ptr_nxt     = ptr_q + AW'(1);
          // The top byte ends the image even without load_last
          if (load_last || (ptr_q == AW'(MEM_SIZE - 1))) begin
            state_nxt     = ST_RUN;
            load_done_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  // Byte storage write port (clear zeros or loaded bytes)
  always_ff @(posedge clk) begin
    if (mem_we_c && !rst) mem[ptr_q] <= mem_wdata_c;
  end

  // Fetch acceptance, alignment check and word assembly
  always_comb begin
    fetch_acc_c = fetch_req && fetch_ready;
    fetch_mis_c = (fetch_addr & AW'(FETCH_BYTES - 1)) != '0;
    rd_word_c   = '0;
    for (int unsigned i = 0; i < FETCH_BYTES; i++) begin
`ifdef IMEM_LITTLE_ENDIAN_EN
      rd_word_c[i*WORD_SIZE +: WORD_SIZE] = mem[fetch_addr + AW'(i)];
`else
      rd_word_c[(FETCH_BYTES-1-i)*WORD_SIZE +: WORD_SIZE] = mem[fetch_addr + AW'(i)];
`endif
    end
  end

  // Registered status and fetch response
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_ready      <= 1'b0;
      fetch_valid      <= 1'b0;
      fetch_data       <= '0;
      fetch_misaligned <= 1'b0;
      load_ready       <= 1'b0;
      load_done        <= 1'b0;
      busy             <= 1'b1;
    end else begin
      fetch_ready <= (state_nxt == ST_RUN);
      load_ready  <= (state_nxt == ST_LOAD);
      busy        <= (state_nxt != ST_RUN);
      load_done   <= load_done_nxt;
      fetch_valid <= fetch_acc_c;
      if (fetch_acc_c) begin
        fetch_misaligned <= fetch_mis_c;
        fetch_data       <= fetch_mis_c ? '0 : rd_word_c;
      end
    end
  end

endmodule

// File: tb/tb_imem_loadable.sv
// tb_imem_loadable: randomized self-checking bench for imem_loadable with a
// byte-array reference model. Honours IMEM_LITTLE_ENDIAN_EN like the design.
module tb_imem_loadable;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [6:0]  fetch_addr;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        fetch_misaligned;
  logic        load_start;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_last;
  logic        load_ready;
  logic        load_done;
  logic        busy;

  int nvec = 0;
  int nerr = 0;
  int done_cnt = 0;
  logic [7:0] mem_m [128];

  imem_loadable #(.MEM_SIZE(128), .WORD_SIZE(8), .FETCH_BYTES(4)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .fetch_misaligned(fetch_misaligned),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Count load_done pulses seen at each rising edge
  always @(posedge clk) if (load_done === 1'b1) done_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected fetch word from the byte model
  function automatic logic [31:0] exp_word(input int a);
    logic [31:0] w;
    w = 32'h0;
    if (a % 4 != 0) return 32'h0;
    for (int i = 0; i < 4; i++) begin
`ifdef IMEM_LITTLE_ENDIAN_EN
      w = w | (32'(mem_m[a+i]) << (8*i));
`else
      w = w | (32'(mem_m[a+i]) << (8*(3-i)));
`endif
    end
    return w;
  endfunction

  task automatic do_fetch(input int a, output logic v, output logic [31:0] d, output logic m);
    @(negedge clk);
    fetch_req  = 1'b1;
    fetch_addr = 7'(a);
    @(posedge clk);
    @(negedge clk);
    fetch_req = 1'b0;
    v = fetch_valid;
    d = fetch_data;
    m = fetch_misaligned;
  endtask

  // Release reset and count cycles until fetch_ready, optionally poking load_start
  task automatic release_and_wait(input bit poke, output int n);
    @(negedge clk);
    rst = 1'b0;
    n = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      load_start = poke && (k == 50);
      if (fetch_ready === 1'b1) begin
        n = k;
        break;
      end
    end
    load_start = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    logic v, m;
    logic [31:0] d;
    rst = 1'b1;
    fetch_req = 1'b0; fetch_addr = '0;
    load_start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    repeat (3) @(negedge clk);
    nvec++;
    if ({fetch_ready, fetch_valid, fetch_data, fetch_misaligned, load_ready, load_done, busy}
        !== {1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      nerr++;
      $display("FAIL reset_outputs: got rdy=%b val=%b data=%h mis=%b lrdy=%b done=%b busy=%b, want 0 0 0 0 0 0 1",
               fetch_ready, fetch_valid, fetch_data, fetch_misaligned, load_ready, load_done, busy);
    end
    for (int i = 0; i < 128; i++) mem_m[i] = 8'h00;
    release_and_wait(1'b1, n);
    nvec++;
    if (n !== 128) begin
      nerr++;
      $display("FAIL clear_duration: got %0d cycles, want 128", n);
    end
    @(negedge clk);
    nvec++;
    if ({load_ready, busy} !== 2'b00) begin
      nerr++;
      $display("FAIL start_in_clear_ignored: got lrdy=%b busy=%b, want 0 0", load_ready, busy);
    end
    do_fetch(0, v, d, m);
    nvec++;
    if ({v, m, d} !== {1'b1, 1'b0, 32'h0}) begin
      nerr++;
      $display("FAIL fetch0_after_clear: got v=%b m=%b d=%h, want 1 0 00000000", v, m, d);
    end
  endtask

  task automatic test_load_image();
    logic [7:0] img [12];
    int d0;
    logic v, m;
    logic [31:0] d;
    img = '{8'hff, 8'hc4, 8'ha3, 8'h03, 8'h00, 8'h83, 8'h23, 8'h83, 8'h00, 8'h64, 8'ha4, 8'h23};
    d0 = done_cnt;
    @(negedge clk);
    load_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_start = 1'b0;
    nvec++;
    if ({load_ready, busy, fetch_ready} !== 3'b110) begin
      nerr++;
      $display("FAIL load_enter: got lrdy=%b busy=%b frdy=%b, want 1 1 0", load_ready, busy, fetch_ready);
    end
    for (int i = 0; i < 12; i++) begin
      load_valid = 1'b1;
      load_data  = img[i];
      load_last  = (i == 11);
      @(posedge clk);
      mem_m[i] = img[i];
      @(negedge clk);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    nvec++;
    if ({load_done, load_ready, fetch_ready, busy} !== 4'b1010) begin
      nerr++;
      $display("FAIL load_end_flags: got done=%b lrdy=%b frdy=%b busy=%b, want 1 0 1 0",
               load_done, load_ready, fetch_ready, busy);
    end
    repeat (2) @(negedge clk);
    nvec++;
    if (done_cnt - d0 !== 1) begin
      nerr++;
      $display("FAIL load_done_pulses: got %0d, want 1", done_cnt - d0);
    end
    do_fetch(0, v, d, m);
    nvec++;
`ifdef IMEM_LITTLE_ENDIAN_EN
    if (d !== 32'h03a3c4ff) begin
      nerr++;
      $display("FAIL image_fetch0: got %h, want 03a3c4ff", d);
    end
`else
    if (d !== 32'hffc4a303) begin
      nerr++;
      $display("FAIL image_fetch0: got %h, want ffc4a303", d);
    end
`endif
    do_fetch(8, v, d, m);
    nvec++;
`ifdef IMEM_LITTLE_ENDIAN_EN
    if (d !== 32'h23a46400) begin
      nerr++;
      $display("FAIL image_fetch8: got %h, want 23a46400", d);
    end
`else
    if (d !== 32'h0064a423) begin
      nerr++;
      $display("FAIL image_fetch8: got %h, want 0064a423", d);
    end
`endif
    do_fetch(4, v, d, m);
    nvec++;
    if ({v, m, d} !== {1'b1, 1'b0, exp_word(4)}) begin
      nerr++;
      $display("FAIL image_fetch4: got v=%b m=%b d=%h, want 1 0 %h", v, m, d, exp_word(4));
    end
  endtask

  task automatic test_misaligned();
    logic v, m;
    logic [31:0] d;
    int a;
    do_fetch(6, v, d, m);
    nvec++;
    if ({v, m, d} !== {1'b1, 1'b1, 32'h0}) begin
      nerr++;
      $display("FAIL misaligned6: got v=%b m=%b d=%h, want 1 1 00000000", v, m, d);
    end
    do_fetch(4, v, d, m);
    nvec++;
    if ({v, m, d} !== {1'b1, 1'b0, exp_word(4)}) begin
      nerr++;
      $display("FAIL aligned4_after_mis: got v=%b m=%b d=%h, want 1 0 %h", v, m, d, exp_word(4));
    end
    for (int k = 0; k < 16; k++) begin
      a = int'($urandom_range(0, 127));
      do_fetch(a, v, d, m);
      nvec++;
      if ({v, m, d} !== {1'b1, (a % 4 != 0), exp_word(a)}) begin
        nerr++;
        $display("FAIL random_fetch a=%0d: got v=%b m=%b d=%h, want 1 %b %h",
                 a, v, m, d, (a % 4 != 0), exp_word(a));
      end
      @(negedge clk);
      nvec++;
      if ({fetch_valid, fetch_misaligned, fetch_data} !== {1'b0, m, d}) begin
        nerr++;
        $display("FAIL fetch_hold a=%0d: got v=%b m=%b d=%h, want 0 %b %h",
                 a, fetch_valid, fetch_misaligned, fetch_data, m, d);
      end
    end
  endtask

  task automatic test_back_to_back();
    int addrs [12];
    for (int k = 0; k < 12; k++) addrs[k] = int'($urandom_range(0, 31)) * 4 + ((k % 3 == 2) ? 1 : 0);
    @(negedge clk);
    fetch_req  = 1'b1;
    fetch_addr = 7'(addrs[0]);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      nvec++;
      if ({fetch_valid, fetch_misaligned, fetch_data}
          !== {1'b1, (addrs[k-1] % 4 != 0), exp_word(addrs[k-1])}) begin
        nerr++;
        $display("FAIL back_to_back a=%0d: got v=%b m=%b d=%h, want 1 %b %h", addrs[k-1],
                 fetch_valid, fetch_misaligned, fetch_data, (addrs[k-1] % 4 != 0), exp_word(addrs[k-1]));
      end
      if (k < 12) fetch_addr = 7'(addrs[k]);
      else fetch_req = 1'b0;
    end
  endtask

  task automatic test_gappy_load();
    int d0, ptr;
    logic [31:0] e;
    logic v, m;
    logic [31:0] d;
    d0 = done_cnt;
    e = exp_word(0);
    @(negedge clk);
    load_start = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = 7'd0;
    @(posedge clk);
    @(negedge clk);
    load_start = 1'b0;
    fetch_req  = 1'b0;
    nvec++;
    if ({fetch_valid, fetch_data, load_ready, fetch_ready} !== {1'b1, e, 1'b1, 1'b0}) begin
      nerr++;
      $display("FAIL fetch_with_start: got v=%b d=%h lrdy=%b frdy=%b, want 1 %h 1 0",
               fetch_valid, fetch_data, load_ready, fetch_ready, e);
    end
    ptr = 0;
    for (int i = 0; i < 19; i++) begin
      load_valid = (i % 2 == 0);
      load_data  = 8'($urandom);
      load_last  = (i == 18);
      load_start = (i == 7);
      @(posedge clk);
      if (load_valid) begin
        mem_m[ptr] = load_data;
        ptr++;
      end
      @(negedge clk);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_start = 1'b0;
    nvec++;
    if ({load_done, fetch_ready, load_ready} !== 3'b110) begin
      nerr++;
      $display("FAIL gappy_end_flags: got done=%b frdy=%b lrdy=%b, want 1 1 0", load_done, fetch_ready, load_ready);
    end
    repeat (2) @(negedge clk);
    nvec++;
    if ({load_ready, busy, fetch_ready, 32'(done_cnt - d0)} !== {3'b001, 32'd1}) begin
      nerr++;
      $display("FAIL gappy_start_not_latched: got lrdy=%b busy=%b frdy=%b pulses=%0d, want 0 0 1 1",
               load_ready, busy, fetch_ready, done_cnt - d0);
    end
    for (int a = 0; a < 16; a += 4) begin
      do_fetch(a, v, d, m);
      nvec++;
      if ({v, m, d} !== {1'b1, 1'b0, exp_word(a)}) begin
        nerr++;
        $display("FAIL gappy_fetch a=%0d: got v=%b m=%b d=%h, want 1 0 %h", a, v, m, d, exp_word(a));
      end
    end
  endtask

  task automatic test_full_load();
    int d0, a;
    logic v, m;
    logic [31:0] d;
    d0 = done_cnt;
    @(negedge clk);
    load_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < 128; i++) begin
      load_valid = 1'b1;
      load_data  = 8'(i);
      load_last  = 1'b0;
      @(posedge clk);
      mem_m[i] = 8'(i);
      @(negedge clk);
    end
    load_valid = 1'b0;
    nvec++;
    if ({load_done, load_ready, fetch_ready} !== 3'b101) begin
      nerr++;
      $display("FAIL full_load_end: got done=%b lrdy=%b frdy=%b, want 1 0 1", load_done, load_ready, fetch_ready);
    end
    repeat (2) @(negedge clk);
    nvec++;
    if (done_cnt - d0 !== 1) begin
      nerr++;
      $display("FAIL full_load_pulses: got %0d, want 1", done_cnt - d0);
    end
    do_fetch(124, v, d, m);
    nvec++;
`ifdef IMEM_LITTLE_ENDIAN_EN
    if (d !== 32'h7f7e7d7c) begin
      nerr++;
      $display("FAIL full_fetch124: got %h, want 7f7e7d7c", d);
    end
`else
    if (d !== 32'h7c7d7e7f) begin
      nerr++;
      $display("FAIL full_fetch124: got %h, want 7c7d7e7f", d);
    end
`endif
    for (int k = 0; k < 6; k++) begin
      a = int'($urandom_range(0, 31)) * 4;
      do_fetch(a, v, d, m);
      nvec++;
      if (d !== exp_word(a)) begin
        nerr++;
        $display("FAIL full_fetch a=%0d: got %h, want %h", a, d, exp_word(a));
      end
    end
  endtask

  task automatic test_reset_midload();
    int n, d0;
    logic v, m;
    logic [31:0] d;
    @(negedge clk);
    fetch_req  = 1'b1;
    fetch_addr = 7'd124;
    rst        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fetch_req = 1'b0;
    nvec++;
    if ({fetch_valid, busy, fetch_ready} !== 3'b010) begin
      nerr++;
      $display("FAIL reset_kills_fetch: got v=%b busy=%b frdy=%b, want 0 1 0", fetch_valid, busy, fetch_ready);
    end
    for (int i = 0; i < 128; i++) mem_m[i] = 8'h00;
    release_and_wait(1'b0, n);
    d0 = done_cnt;
    @(negedge clk);
    load_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1;
      load_data  = 8'($urandom_range(1, 255));
      load_last  = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    load_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    nvec++;
    if ({load_ready, load_done, busy} !== 3'b001) begin
      nerr++;
      $display("FAIL reset_midload_flags: got lrdy=%b done=%b busy=%b, want 0 0 1", load_ready, load_done, busy);
    end
    release_and_wait(1'b0, n);
    nvec++;
    if (n !== 128) begin
      nerr++;
      $display("FAIL reclear_duration: got %0d cycles, want 128", n);
    end
    do_fetch(0, v, d, m);
    nvec++;
    if ({v, d, 32'(done_cnt - d0)} !== {1'b1, 32'h0, 32'd0}) begin
      nerr++;
      $display("FAIL reclear_fetch0: got v=%b d=%h pulses=%0d, want 1 00000000 0", v, d, done_cnt - d0);
    end
    do_fetch(4, v, d, m);
    nvec++;
    if (d !== exp_word(4)) begin
      nerr++;
      $display("FAIL reclear_fetch4: got %h, want %h", d, exp_word(4));
    end
  endtask

  initial begin
    test_reset();
    test_load_image();
    test_misaligned();
    test_back_to_back();
    test_gappy_load();
    test_full_load();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/imem_loadable.md
# imem_loadable

Parametrised, byte-addressed instruction memory with a fetch port and a byte-serial program-load port. It replaces hard-wired reset contents with a runtime loader, so a bootloader or testbench can stream a program image in after reset. After reset it self-clears one byte per cycle. Fetch is a registered one-cycle-latency read that flags misaligned addresses. It sits between the PC/fetch stage and the boot/debug path of the RISC-V core.

## Interface
- `MEM_SIZE`, 128: memory depth in bytes; power of two, ≥ `FETCH_BYTES`.
- `WORD_SIZE`, 8: bits per byte location.
- `FETCH_BYTES`, 4: bytes per fetched instruction; power of two.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `fetch_req` in 1: fetch request, sampled only while `fetch_ready`=1.
- `fetch_addr` in `$clog2(MEM_SIZE)`: byte address of the instruction.
- `fetch_ready` out 1: memory is in RUN and accepts fetches.
- `fetch_valid` out 1: `fetch_data` and `fetch_misaligned` are valid this cycle.
- `fetch_data` out `WORD_SIZE*FETCH_BYTES`: instruction word.
- `fetch_misaligned` out 1: the accepted address was not a multiple of `FETCH_BYTES`.
- `load_start` in 1: begin a program load; honoured only in RUN.
- `load_valid` in 1: `load_data` carries a byte.
- `load_data` in `WORD_SIZE`: program byte.
- `load_last` in 1: qualifies the final byte of the image.
- `load_ready` out 1: high in LOAD; a byte is accepted when `load_valid && load_ready`.
- `load_done` out 1: one-cycle pulse when a load completes.
- `busy` out 1: high in CLEAR or LOAD.

## Operation
- States: CLEAR, RUN, LOAD.
- `rst`=1 forces CLEAR with clear pointer 0. Reset outputs: `fetch_ready`=0, `fetch_valid`=0, `fetch_data`=0, `fetch_misaligned`=0, `load_ready`=0, `load_done`=0, `busy`=1.
- CLEAR: writes 0 to byte[ptr] and increments ptr each cycle. After byte `MEM_SIZE-1` is written, the next state is RUN.
- RUN: `fetch_ready`=1.
  - `load_start`=1 moves to LOAD with load pointer 0.
  - A fetch accepted in the same cycle as `load_start` still completes.
- LOAD: each accepted byte is written to byte[ptr] and ptr increments.
  - Load ends when the accepted byte has `load_last`=1, or when ptr = `MEM_SIZE-1`; the latter is an implicit last.
  - On load end: next state is RUN and `load_done` pulses for 1 cycle.
  - Bytes not overwritten keep their previous value.
  - `load_start` during LOAD or CLEAR is ignored and is not latched.
- Fetch (accepted when `fetch_req && fetch_ready`):
  - Misaligned: the low `$clog2(FETCH_BYTES)` address bits ≠ 0. Result: `fetch_misaligned`=1 and `fetch_data`=0.
  - Aligned: `fetch_data` is byte[a]..byte[a+FETCH_BYTES-1], ordered per Configuration. There is no wrap, because aligned addresses never cross `MEM_SIZE`.
- `fetch_req` while `fetch_ready`=0 is dropped; no response is generated.
- `fetch_data` and `fetch_misaligned` hold their last values when `fetch_valid`=0.

## Timing
- Fetch latency: request accepted in cycle N gives `fetch_valid`=1 in cycle N+1. Back-to-back fetches give one result per cycle.
- A byte written in LOAD cycle N is visible to a fetch accepted in cycle N+1 or later.
- CLEAR duration: the first cycle with `rst`=0 writes byte 0. `fetch_ready` rises exactly `MEM_SIZE` cycles after `rst` falls.
- `rst` asserted in any state, including mid-load or with a fetch in flight: next cycle is CLEAR, the in-flight `fetch_valid` is suppressed, and memory is re-zeroed.
- `load_ready` falls and `fetch_ready` rises in the cycle after the last byte is accepted, coincident with `load_done`.

## Configuration
- `IMEM_LITTLE_ENDIAN_EN` defined: `fetch_data` = {byte[a+FETCH_BYTES-1], …, byte[a]}, RISC-V native order.
- `IMEM_LITTLE_ENDIAN_EN` undefined: `fetch_data` = {byte[a], …, byte[a+FETCH_BYTES-1]}, big-endian image order.

## Test plan
- Release `rst` → `fetch_ready` rises exactly 128 cycles later; fetch addr 0 → `fetch_data`=0x00000000 one cycle after acceptance.
- Load ff c4 a3 03 00 83 23 83 00 64 a4 23 with `load_last` on the 12th byte → single `load_done` pulse.
  - Big-endian build: fetch 0 → 0xffc4a303, fetch 8 → 0x0064a423.
  - Little-endian build: fetch 0 → 0x03a3c4ff.
- In RUN, fetch addr 6 → `fetch_valid`=1, `fetch_misaligned`=1, `fetch_data`=0. The next fetch of addr 4 → `fetch_misaligned`=0.
- Load with `load_valid` toggling every other cycle and `load_start` pulsed mid-load → only valid bytes are stored, in order; the second start is ignored.
- Load 128 bytes (value = index) without `load_last` → load ends after byte 127 with `load_done`; big-endian fetch 124 → 0x7c7d7e7f.
- Assert `rst` after 5 loaded bytes → CLEAR restarts; 128 cycles after release, fetch 0 → 0x00000000 and `load_done` is never pulsed.
